// File: rtl/imuldiv_muldiv_wb_tracker_pkg.sv
// Shared mul/div definitions: function encodings, tag layout and result-half select.
package imuldiv_muldiv_wb_tracker_pkg;

  typedef enum logic [2:0] {
    FN_MUL  = 3'd0,
    FN_DIV  = 3'd1,
    FN_DIVU = 3'd2,
    FN_REM  = 3'd3,
    FN_REMU = 3'd4
  } muldiv_fn_e;

  localparam int TAG_FN_W = 3;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  // Remainders live in the upper word of the unit result; everything else uses the lower word.
  function automatic logic half_sel(input logic [2:0] fn);
    return (fn == FN_REM || fn == FN_REMU) ? HALF_HI : HALF_LO;
  endfunction

endpackage

// File: rtl/imuldiv_tag_fifo.sv
// Generic DEPTH x W in-order FIFO with full/empty flags; no push-to-pop bypass.
module imuldiv_tag_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [PTR_W:0]   count;
  logic             do_push, do_pop;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/imuldiv_muldiv_wb_tracker.sv
// Mul/div request-tag tracker and registered writeback select.
// Optional sticky protocol error flag: define IMULDIV_WB_TRACKER_ERR_EN.
module imuldiv_muldiv_wb_tracker
  import imuldiv_muldiv_wb_tracker_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req_val,
  output logic              cpu_req_rdy,
  input  logic [2:0]        cpu_req_fn,
  input  logic [ADDR_W-1:0] cpu_req_waddr,
  output logic              unit_req_val,
  input  logic              unit_req_rdy,
  input  logic              unit_resp_val,
  output logic              unit_resp_rdy,
  input  logic [63:0]       unit_resp_msg_result,
  output logic              wb_val,
  input  logic              wb_rdy,
  output logic [31:0]       wb_data,
  output logic [ADDR_W-1:0] wb_waddr,
  output logic [2:0]        wb_fn,
  output logic              wb_err
);

  localparam int TAG_W = TAG_FN_W + ADDR_W;

  logic             tag_full, tag_empty;
  logic [TAG_W-1:0] head_tag, resp_tag;
  logic             req_fire, resp_fire;
  logic [2:0]       resp_fn;
  logic [31:0]      sel_data;

  // Full gating only: cpu_req_rdy never depends on the response side.
  assign cpu_req_rdy   = unit_req_rdy && !tag_full;
  assign unit_req_val  = cpu_req_val && !tag_full;
  assign unit_resp_rdy = !wb_val || wb_rdy;

  assign req_fire  = cpu_req_val && cpu_req_rdy;
  assign resp_fire = unit_resp_val && unit_resp_rdy;

  imuldiv_tag_fifo #(.DEPTH(DEPTH), .W(TAG_W)) u_tagq (
    .clk       (clk),
    .reset     (reset),
    .push      (req_fire),
    .push_data ({cpu_req_fn, cpu_req_waddr}),
    .pop       (resp_fire),
    .pop_data  (head_tag),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  // An orphan response is written back as a MUL to register 0.
  assign resp_tag = tag_empty ? {FN_MUL, {ADDR_W{1'b0}}} : head_tag;
  assign resp_fn  = resp_tag[TAG_W-1 -: TAG_FN_W];
  assign sel_data = (half_sel(resp_fn) == HALF_HI) ? unit_resp_msg_result[63:32]
                                                   : unit_resp_msg_result[31:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_val   <= 1'b0;
      wb_data  <= '0;
      wb_waddr <= '0;
      wb_fn    <= '0;
    end else if (resp_fire) begin
      wb_val   <= 1'b1;
      wb_data  <= sel_data;
      wb_waddr <= resp_tag[ADDR_W-1:0];
      wb_fn    <= resp_fn;
    end else if (wb_rdy) begin
      wb_val   <= 1'b0;
    end
  end

`ifdef IMULDIV_WB_TRACKER_ERR_EN
  logic err_q;

  // Push-while-full can only arise if the gating above is bypassed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else if ((resp_fire && tag_empty) || (req_fire && tag_full)) err_q <= 1'b1;
  end

  assign wb_err = err_q;
`else
  assign wb_err = 1'b0;
`endif

endmodule
